alu_issue: RTL and testbench



---
 rtl/alu_issue.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_issue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes one instruction into ALU operands/op code and registers it behind a valid/ready handshake.
// Optional macro ALU_ISSUE_SKID_EN selects a 2-entry skid buffer with a registered in_ready.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_control,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // a producer holding valid keeps its payload stable until that transfer.

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        illegal;
  } issue_t;

  issue_t      dec;
  issue_t      out_q;
  logic        out_valid_q;
  logic        in_xfer;
  logic        out_xfer;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        unused_rs1_idx;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign shamt  = {27'b0, in_instr[24:20]};
  assign unused_rs1_idx = ^in_instr[19:15];

  always_comb begin
    dec         = '0;
    dec.rd      = in_instr[11:7];
    dec.ctrl    = ALU_ADD;
    dec.illegal = 1'b0;
    case (opcode)
      OP_R: begin
        dec.a = in_rs1_data;
        dec.b = in_rs2_data;
        if (funct7 == F7_ZERO) begin
          case (funct3)
            3'b000:  dec.ctrl = ALU_ADD;
            3'b001:  dec.ctrl = ALU_SLL;
            3'b010:  dec.ctrl = ALU_SLT;
            3'b011:  dec.ctrl = ALU_SLTU;
            3'b100:  dec.ctrl = ALU_XOR;
            3'b101:  dec.ctrl = ALU_SRL;
            3'b110:  dec.ctrl = ALU_OR;
            default: dec.ctrl = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.ctrl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.ctrl = ALU_SRA;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec.a = in_rs1_data;
        dec.b = imm_i;
        case (funct3)
          3'b000:  dec.ctrl = ALU_ADD;
          3'b010:  dec.ctrl = ALU_SLT;
          3'b011:  dec.ctrl = ALU_SLTU;
          3'b100:  dec.ctrl = ALU_XOR;
          3'b110:  dec.ctrl = ALU_OR;
          3'b111:  dec.ctrl = ALU_AND;
          3'b001: begin
            dec.b       = shamt;
            dec.ctrl    = ALU_SLL;
            dec.illegal = (funct7 != F7_ZERO);
          end
          default: begin
            dec.b       = shamt;
            dec.ctrl    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
          end
        endcase
      end
      OP_LUI: begin
        dec.a = '0;
        dec.b = imm_u;
      end
      OP_AUIPC: begin
        dec.a = in_pc;
        dec.b = imm_u;
      end
      OP_LOAD: begin
        dec.a = in_rs1_data;
        dec.b = imm_i;
      end
      OP_STORE: begin
        dec.a = in_rs1_data;
        dec.b = imm_s;
      end
      OP_BRANCH: begin
        dec.a = in_rs1_data;
        dec.b = in_rs2_data;
        case (funct3)
          3'b000, 3'b001: dec.ctrl = ALU_SUB;
          3'b100, 3'b101: dec.ctrl = ALU_SLT;
          3'b110, 3'b111: dec.ctrl = ALU_SLTU;
          default:        dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions still issue, but as a harmless 0 + 0.
    if (dec.illegal) begin
      dec.a    = '0;
      dec.b    = '0;
      dec.ctrl = ALU_ADD;
    end
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_full;

  // Registered ready: the second entry absorbs the one transfer accepted after out_ready drops.
  assign in_ready = !skid_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full   <= 1'b0;
    end else if (skid_full) begin
      if (out_xfer) begin
        out_q     <= skid_q;
        skid_full <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_valid_q || out_xfer) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        skid_q    <= dec;
        skid_full <= 1'b1;
      end
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid_q | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_xfer) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid       = out_valid_q;
  assign out_a           = out_q.a;
  assign out_b           = out_q.b;
  assign out_alu_control = out_q.ctrl;
  assign out_rd          = out_q.rd;
  assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, streaming, backpressure and reset.
module tb_alu_issue;

`ifdef ALU_ISSUE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_control;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_alu_control(out_alu_control), .out_rd(out_rd),
    .out_illegal(out_illegal)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one instruction and returns #1 after the edge on which it was accepted.
  task automatic send_one(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    in_rs1_data = rs1; in_rs2_data = rs2;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept: instr=%h never accepted, required accept within 20 cycles", instr);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_alu_control, out_rd, out_illegal} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%h b=%h c=%h rd=%0d ill=%b, required all zero",
               out_valid, out_a, out_b, out_alu_control, out_rd, out_illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_decode;
    vec_t v[16];
    v[0]  = '{32'h002081B3, 32'h0, 32'd5,        32'd7,    32'd5,        32'd7,        4'b0000, 5'd3,  1'b0};
    v[1]  = '{32'h402081B3, 32'h0, 32'd9,        32'd4,    32'd9,        32'd4,        4'b0001, 5'd3,  1'b0};
    v[2]  = '{32'h4040D193, 32'h0, 32'h80000000, 32'hDEAD, 32'h80000000, 32'd4,        4'b0111, 5'd3,  1'b0};
    v[3]  = '{32'h123452B7, 32'h0, 32'h55,       32'h66,   32'h0,        32'h12345000, 4'b0000, 5'd5,  1'b0};
    v[4]  = '{32'h12345297, 32'h100, 32'h55,     32'h66,   32'h100,      32'h12345000, 4'b0000, 5'd5,  1'b0};
    v[5]  = '{32'hFFFFFFFF, 32'h40, 32'h11,      32'h22,   32'h0,        32'h0,        4'b0000, 5'd31, 1'b1};
    v[6]  = '{32'hFFF00093, 32'h0, 32'd10,       32'd3,    32'd10,       32'hFFFFFFFF, 4'b0000, 5'd1,  1'b0};
    v[7]  = '{32'h00812083, 32'h0, 32'h1000,     32'd3,    32'h1000,     32'd8,        4'b0000, 5'd1,  1'b0};
    v[8]  = '{32'hFE20AE23, 32'h0, 32'h2000,     32'h77,   32'h2000,     32'hFFFFFFFC, 4'b0000, 5'd28, 1'b0};
    v[9]  = '{32'h0020E063, 32'h0, 32'd3,        32'd4,    32'd3,        32'd4,        4'b1001, 5'd0,  1'b0};
    v[10] = '{32'h0020A063, 32'h0, 32'd3,        32'd4,    32'h0,        32'h0,        4'b0000, 5'd0,  1'b1};
    v[11] = '{32'h40209093, 32'h0, 32'd3,        32'd4,    32'h0,        32'h0,        4'b0000, 5'd1,  1'b1};
    v[12] = '{32'h402091B3, 32'h0, 32'd3,        32'd4,    32'h0,        32'h0,        4'b0000, 5'd3,  1'b1};
    v[13] = '{32'h0020B1B3, 32'h0, 32'd1,        32'd2,    32'd1,        32'd2,        4'b1001, 5'd3,  1'b0};
    v[14] = '{32'h0FF0C093, 32'h0, 32'd6,        32'd9,    32'd6,        32'hFF,       4'b0100, 5'd1,  1'b0};
    v[15] = '{32'h022081B3, 32'h0, 32'd3,        32'd4,    32'h0,        32'h0,        4'b0000, 5'd3,  1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_one(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      checks++;
      if ({out_valid, out_a, out_b, out_alu_control, out_rd, out_illegal} !==
          {1'b1, v[i].a, v[i].b, v[i].ctrl, v[i].rd, v[i].ill}) begin
        errors++;
        $display("FAIL decode[%0d] instr=%h: got v=%b a=%h b=%h c=%b rd=%0d ill=%b, required v=1 a=%h b=%h c=%b rd=%0d ill=%b",
                 i, v[i].instr, out_valid, out_a, out_b, out_alu_control, out_rd, out_illegal,
                 v[i].a, v[i].b, v[i].ctrl, v[i].rd, v[i].ill);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = '0;
      in_rs1_data = 32'(i * 3 + 1); in_rs2_data = 32'(i);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
      end
      exp_q.push_back(32'(i * 3 + 1));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_a !== e) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got v=%b a=%h, required v=1 a=%h", i, out_valid, out_a, e);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] items[3];
    logic [31:0] e;
    int idx;
    int issued;
    logic acc;
    items[0] = 32'h11; items[1] = 32'h22; items[2] = 32'h33;
    idx = 0;
    issued = 0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = '0;
      in_rs1_data = items[idx]; in_rs2_data = 32'h1;
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(items[idx]);
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'h11) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got v=%b a=%h, required v=1 a=00000011", c, out_valid, out_a);
        end
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    checks++;
    if (idx != CAP) begin
      errors++;
      $display("FAIL bp_accepted: got %0d, required %0d", idx, CAP);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready: got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        issued++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: got a=%h, required no further issue", out_a);
        end else begin
          e = exp_q.pop_front();
          if (out_a !== e) begin
            errors++;
            $display("FAIL bp_order: got a=%h, required a=%h", out_a, e);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (issued != CAP || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_issued: got %0d issued (%0d left), required %0d issued", issued, exp_q.size(), CAP);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send_one(32'h002081B3, 32'h0, 32'hAAAA, 32'h1);
`ifdef ALU_ISSUE_SKID_EN
    send_one(32'h002081B3, 32'h0, 32'hBBBB, 32'h1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b a=%h, required v=0 a=0", out_valid, out_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_ready: got %b, required 1", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_idle[%0d]: got out_valid=%b, required 0", c, out_valid);
      end
    end
    @(posedge clk);
    #1;
    send_one(32'h002081B3, 32'h0, 32'hCCCC, 32'h2);
    checks++;
    if (out_valid !== 1'b1 || out_a !== 32'hCCCC) begin
      errors++;
      $display("FAIL rst_mid_fresh: got v=%b a=%h, required v=1 a=0000cccc", out_valid, out_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drain: got out_valid=%b, required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
